// File: rtl/lcd_hd44780_model_if.sv
// Character-LCD bus between the LCD driver (master) and the HD44780 responder model (slave).
interface lcd_hd44780_model_if;
    logic       en;
    logic       RS;
    logic       RW;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       dataOE;

    modport master (
        output en,
        output RS,
        output RW,
        output dataIn,
        input  dataOut,
        input  dataOE
    );

    modport slave (
        input  en,
        input  RS,
        input  RW,
        input  dataIn,
        output dataOut,
        output dataOE
    );
endinterface

// File: rtl/lcd_hd44780_model.sv
// HD44780-style LCD responder: decodes driver bus cycles into an 80-byte DDRAM,
// keeps AC and control bits, models the busy flag and exposes DDRAM on a debug port.
module lcd_hd44780_model #(
    parameter int BUSY_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 96
) (
    input  logic                clk,
    input  logic                rst,
    lcd_hd44780_model_if.slave  bus,
    output logic                busy,
    output logic [6:0]          addr,
    output logic                dispOn,
    output logic                cursorOn,
    output logic                blinkOn,
    output logic                twoLine,
    output logic                incMode,
    output logic                err,
    input  logic [6:0]          dbgAddr,
    output logic [7:0]          dbgChar
);

    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DEPTH   = 80;

    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [6:0]       LAST_IDX   = 7'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CLEAR
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             fill_on_reg;
    logic [6:0]       fill_idx_reg;
    logic             en_q_reg;
    logic [6:0]       addr_reg;
    logic             disp_on_reg;
    logic             cursor_on_reg;
    logic             blink_on_reg;
    logic             two_line_reg;
    logic             inc_mode_reg;
    logic             err_reg;
    logic [7:0]       data_out_reg;
    logic             data_oe_reg;
    logic             rd_data_reg;
    logic [7:0]       dbg_char_reg;

    logic [7:0]       ddram [0:DEPTH-1];

    logic             rise;
    logic             fall;
    logic             idle;
    logic             wr_data_ok;
    logic             mem_we;
    logic [6:0]       mem_widx;
    logic [7:0]       mem_wdata;

    // AC walks line 1 (0x00-0x27) then line 2 (0x40-0x67), wrapping in both directions.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h00)      return 7'h67;
            else if (a == 7'h40) return 7'h27;
            else                 return a - 7'd1;
        end
    endfunction

    function automatic logic [6:0] ddram_idx(input logic [6:0] a);
        return a[6] ? (a - 7'd24) : a;
    endfunction

    function automatic logic addr_ok(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    assign rise       = bus.en & ~en_q_reg;
    assign fall       = ~bus.en & en_q_reg;
    assign idle       = (state_reg == ST_IDLE);
    assign wr_data_ok = fall && idle && bus.RS && !bus.RW;

    // The fill only runs in CLEAR and data writes only in IDLE, so the two never collide.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = 7'd0;
        mem_wdata = 8'h00;
        if (rst && fill_on_reg) begin
            mem_we    = 1'b1;
            mem_widx  = fill_idx_reg;
            mem_wdata = 8'h20;
        end else if (rst && wr_data_ok) begin
            mem_we    = 1'b1;
            mem_widx  = ddram_idx(addr_reg);
            mem_wdata = bus.dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            ddram[mem_widx] <= mem_wdata;
        end
        dbg_char_reg <= addr_ok(dbgAddr) ? ddram[ddram_idx(dbgAddr)] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q_reg      <= 1'b0;
            state_reg     <= ST_CLEAR;
            cnt_reg       <= CLEAR_LOAD;
            fill_on_reg   <= 1'b1;
            fill_idx_reg  <= 7'd0;
            addr_reg      <= 7'd0;
            disp_on_reg   <= 1'b0;
            cursor_on_reg <= 1'b0;
            blink_on_reg  <= 1'b0;
            two_line_reg  <= 1'b0;
            inc_mode_reg  <= 1'b1;
            err_reg       <= 1'b0;
            data_out_reg  <= 8'h00;
            data_oe_reg   <= 1'b0;
            rd_data_reg   <= 1'b0;
        end else begin
            en_q_reg <= bus.en;

            if (state_reg != ST_IDLE) begin
                if (cnt_reg == '0) begin
                    state_reg <= ST_IDLE;
                end else begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end

            if (fill_on_reg) begin
                fill_idx_reg <= fill_idx_reg + 7'd1;
                if (fill_idx_reg == LAST_IDX) begin
                    fill_on_reg <= 1'b0;
                end
            end

            if (rise && bus.RW) begin
                if (!bus.RS) begin
                    data_oe_reg  <= 1'b1;
                    data_out_reg <= {busy, addr_reg};
                end else if (idle) begin
                    data_oe_reg  <= 1'b1;
                    data_out_reg <= ddram[ddram_idx(addr_reg)];
                    rd_data_reg  <= 1'b1;
                end else begin
                    err_reg <= 1'b1;
                end
            end

            if (fall) begin
                data_oe_reg <= 1'b0;
                if (bus.RW) begin
                    // AC advances only for a data read that was accepted on the rise.
                    if (rd_data_reg) begin
                        addr_reg    <= addr_step(addr_reg, inc_mode_reg);
                        rd_data_reg <= 1'b0;
                    end
                end else if (!idle) begin
                    err_reg <= 1'b1;
                end else if (bus.RS) begin
                    addr_reg  <= addr_step(addr_reg, inc_mode_reg);
                    state_reg <= ST_WAIT;
                    cnt_reg   <= BUSY_LOAD;
                end else begin
                    if (bus.dataIn[7:2] != 6'd0) begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= BUSY_LOAD;
                    end
                    casez (bus.dataIn)
                        8'b1???_????: begin
                            if (addr_ok(bus.dataIn[6:0])) begin
                                addr_reg <= bus.dataIn[6:0];
                            end else begin
                                err_reg <= 1'b1;
                            end
                        end
                        8'b01??_????: begin
                        end
                        8'b001?_????: begin
                            two_line_reg <= bus.dataIn[3];
                        end
                        8'b0001_????: begin
                            if (!bus.dataIn[3]) begin
                                addr_reg <= addr_step(addr_reg, bus.dataIn[2]);
                            end
                        end
                        8'b0000_1???: begin
                            disp_on_reg   <= bus.dataIn[2];
                            cursor_on_reg <= bus.dataIn[1];
                            blink_on_reg  <= bus.dataIn[0];
                        end
                        8'b0000_01??: begin
                            inc_mode_reg <= bus.dataIn[1];
                        end
                        8'b0000_001?: begin
                            // Return home shares the long clear timer but leaves DDRAM alone.
                            addr_reg    <= 7'd0;
                            state_reg   <= ST_CLEAR;
                            cnt_reg     <= CLEAR_LOAD;
                            fill_on_reg <= 1'b0;
                        end
                        8'b0000_0001: begin
                            addr_reg     <= 7'd0;
                            inc_mode_reg <= 1'b1;
                            state_reg    <= ST_CLEAR;
                            cnt_reg      <= CLEAR_LOAD;
                            fill_on_reg  <= 1'b1;
                            fill_idx_reg <= 7'd0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign addr        = addr_reg;
    assign dispOn      = disp_on_reg;
    assign cursorOn    = cursor_on_reg;
    assign blinkOn     = blink_on_reg;
    assign twoLine     = two_line_reg;
    assign incMode     = inc_mode_reg;
    assign err         = err_reg;
    assign dbgChar     = dbg_char_reg;
    assign bus.dataOut = data_out_reg;
    assign bus.dataOE  = data_oe_reg;

endmodule

// File: tb/tb_lcd_hd44780_model.sv
// Self-checking bench for lcd_hd44780_model: instruction/data table plus busy, read and reset sequences.
module tb_lcd_hd44780_model;

    localparam int BUSY = 4;
    localparam int CLR  = 96;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [6:0] addr;
    logic       dispOn, cursorOn, blinkOn, twoLine, incMode, err;
    logic [6:0] dbgAddr;
    logic [7:0] dbgChar;

    always #5 clk = ~clk;

    lcd_hd44780_model_if bus();

    lcd_hd44780_model #(
        .BUSY_CYCLES  (BUSY),
        .CLEAR_CYCLES (CLR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .addr     (addr),
        .dispOn   (dispOn),
        .cursorOn (cursorOn),
        .blinkOn  (blinkOn),
        .twoLine  (twoLine),
        .incMode  (incMode),
        .err      (err),
        .dbgAddr  (dbgAddr),
        .dbgChar  (dbgChar)
    );

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [6:0] a;
        logic [4:0] f;
        logic       e;
        int         b;
    } vec_t;
    vec_t vt[21];

    logic [7:0] shadow [80];

    function automatic int tb_idx(input logic [6:0] a);
        return (a >= 7'h40) ? (int'(a) - 64 + 40) : int'(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [7:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [7:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'(sb_q.size()), 1);
        end else begin
            e = sb_q.pop_front();
            check(e.name, {24'd0, act}, {24'd0, e.val});
        end
    endtask

    task automatic lcd_write(input logic rs, input logic [7:0] d);
        bus.RS     = rs;
        bus.RW     = 1'b0;
        bus.dataIn = d;
        bus.en     = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
    endtask

    task automatic lcd_read(input logic rs, input string name, input logic [7:0] exp);
        sb_push(name, exp);
        check({name, "_oe_pre"}, {31'd0, bus.dataOE}, 0);
        bus.RS = rs;
        bus.RW = 1'b1;
        bus.en = 1'b1;
        @(negedge clk);
        check({name, "_oe_during"}, {31'd0, bus.dataOE}, 1);
        sb_pop_check(bus.dataOut);
        bus.en = 1'b0;
        @(negedge clk);
        check({name, "_oe_after"}, {31'd0, bus.dataOE}, 0);
        bus.RW = 1'b0;
        $display("read  rs=%0d dataOut=%02h exp=%02h", rs, bus.dataOut, exp);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic dbg_check(input logic [6:0] a, input logic [7:0] exp);
        sb_push($sformatf("dbg_%02h", a), exp);
        dbgAddr = a;
        @(negedge clk);
        sb_pop_check(dbgChar);
    endtask

    task automatic dbg_sweep();
        logic [6:0] a;
        for (int i = 0; i < 80; i++) begin
            a = (i < 40) ? 7'(i) : 7'(i - 40 + 64);
            dbg_check(a, shadow[i]);
        end
        $display("sweep 80 DDRAM cells via debug port");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [6:0] prev_addr;

        rst        = 1'b0;
        bus.en     = 1'b0;
        bus.RS     = 1'b0;
        bus.RW     = 1'b0;
        bus.dataIn = 8'h00;
        dbgAddr    = 7'd0;

        vt[0]  = '{1'b0, 8'h38, 7'h00, 5'b00011, 1'b0, BUSY};
        vt[1]  = '{1'b0, 8'h0F, 7'h00, 5'b11111, 1'b0, BUSY};
        vt[2]  = '{1'b0, 8'h06, 7'h00, 5'b11111, 1'b0, BUSY};
        vt[3]  = '{1'b1, 8'h48, 7'h01, 5'b11111, 1'b0, BUSY};
        vt[4]  = '{1'b1, 8'h49, 7'h02, 5'b11111, 1'b0, BUSY};
        vt[5]  = '{1'b0, 8'hA7, 7'h27, 5'b11111, 1'b0, BUSY};
        vt[6]  = '{1'b1, 8'h41, 7'h40, 5'b11111, 1'b0, BUSY};
        vt[7]  = '{1'b0, 8'h04, 7'h40, 5'b11110, 1'b0, BUSY};
        vt[8]  = '{1'b1, 8'h42, 7'h27, 5'b11110, 1'b0, BUSY};
        vt[9]  = '{1'b0, 8'h80, 7'h00, 5'b11110, 1'b0, BUSY};
        vt[10] = '{1'b1, 8'h43, 7'h67, 5'b11110, 1'b0, BUSY};
        vt[11] = '{1'b0, 8'h06, 7'h67, 5'b11111, 1'b0, BUSY};
        vt[12] = '{1'b0, 8'h14, 7'h00, 5'b11111, 1'b0, BUSY};
        vt[13] = '{1'b0, 8'h10, 7'h67, 5'b11111, 1'b0, BUSY};
        vt[14] = '{1'b0, 8'h1C, 7'h67, 5'b11111, 1'b0, BUSY};
        vt[15] = '{1'b0, 8'h08, 7'h67, 5'b00011, 1'b0, BUSY};
        vt[16] = '{1'b0, 8'h20, 7'h67, 5'b00001, 1'b0, BUSY};
        vt[17] = '{1'b0, 8'h00, 7'h67, 5'b00001, 1'b0, 0};
        vt[18] = '{1'b0, 8'h02, 7'h00, 5'b00001, 1'b0, CLR};
        vt[19] = '{1'b0, 8'h85, 7'h05, 5'b00001, 1'b0, BUSY};
        vt[20] = '{1'b0, 8'hB0, 7'h05, 5'b00001, 1'b1, BUSY};

        for (int i = 0; i < 80; i++) shadow[i] = 8'h20;

        // Reset state and the power-up clear period.
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 1);
        check("rst_addr", {25'd0, addr}, 0);
        check("rst_flags", {27'd0, dispOn, cursorOn, blinkOn, twoLine, incMode}, 32'h01);
        check("rst_err", {31'd0, err}, 0);
        check("rst_oe", {31'd0, bus.dataOE}, 0);
        check("rst_dataout", {24'd0, bus.dataOut}, 0);
        rst = 1'b1;
        wait_idle(n);
        check("clear_busy_len", n, CLR);
        $display("reset released, busy for %0d cycles", n);
        lcd_read(1'b0, "status_idle", 8'h00);
        dbg_sweep();

        prev_addr = 7'h00;
        for (int i = 0; i < 21; i++) begin
            lcd_write(vt[i].rs, vt[i].d);
            if (vt[i].rs) shadow[tb_idx(prev_addr)] = vt[i].d;
            wait_idle(n);
            check($sformatf("v%0d_busy_len", i), n, vt[i].b);
            check($sformatf("v%0d_addr", i), {25'd0, addr}, {25'd0, vt[i].a});
            check($sformatf("v%0d_flags", i), {27'd0, dispOn, cursorOn, blinkOn, twoLine, incMode},
                  {27'd0, vt[i].f});
            check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vt[i].e});
            prev_addr = vt[i].a;
            $display("vec %0d rs=%0d data=%02h addr=%02h busy_len=%0d err=%0d",
                     i, vt[i].rs, vt[i].d, addr, n, err);
        end

        lcd_read(1'b0, "status_after_tbl", 8'h05);
        dbg_sweep();

        // Data read at a known address.
        lcd_write(1'b1, 8'h55);
        shadow[5] = 8'h55;
        wait_idle(n);
        lcd_write(1'b0, 8'h85);
        wait_idle(n);
        lcd_read(1'b1, "rd_data", 8'h55);
        check("rd_addr_step", {25'd0, addr}, 32'h06);
        check("rd_no_busy", {31'd0, busy}, 0);

        // Fresh reset so err starts clear for the busy-access checks.
        do_reset(3);
        wait_idle(n);
        check("clear2_busy_len", n, CLR);
        check("clear2_err", {31'd0, err}, 0);
        for (int i = 0; i < 80; i++) shadow[i] = 8'h20;
        dbg_check(7'h05, 8'h20);

        lcd_write(1'b0, 8'h0C);
        lcd_read(1'b0, "status_busy", 8'h80);
        check("status_busy_err", {31'd0, err}, 0);
        wait_idle(n);

        // Data write landing inside the WAIT window.
        lcd_write(1'b0, 8'h06);
        lcd_write(1'b1, 8'h77);
        wait_idle(n);
        check("busywr_busy_len", n, BUSY - 2);
        check("busywr_err", {31'd0, err}, 1);
        check("busywr_addr", {25'd0, addr}, 0);
        dbg_check(7'h00, 8'h20);

        // Clear instruction wipes DDRAM and restores increment mode.
        lcd_write(1'b0, 8'hE7);
        wait_idle(n);
        lcd_write(1'b1, 8'h5A);
        wait_idle(n);
        dbg_check(7'h67, 8'h5A);
        lcd_write(1'b0, 8'h04);
        wait_idle(n);
        lcd_write(1'b0, 8'h01);
        wait_idle(n);
        check("clrinst_busy_len", n, CLR);
        check("clrinst_inc", {31'd0, incMode}, 1);
        check("clrinst_addr", {25'd0, addr}, 0);
        dbg_check(7'h67, 8'h20);

        // Reset in the middle of the power-up clear restarts the whole period.
        lcd_write(1'b0, 8'hE7);
        wait_idle(n);
        lcd_write(1'b1, 8'h5A);
        wait_idle(n);
        do_reset(2);
        repeat (30) @(negedge clk);
        do_reset(2);
        wait_idle(n);
        check("midclear_busy_len", n, CLR);
        check("midclear_err", {31'd0, err}, 0);
        dbg_check(7'h67, 8'h20);
        $display("mid-clear reset, busy for %0d cycles", n);

        check("sb_leftover", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
